// File: rtl/serial_operand_transmitter_if.sv
// serial_operand_transmitter_if: operand handshake plus serial output bundle.
// Defining SERIAL_TX_CLEAR_EN adds the cmp_clr comparator-clear strobe.
interface serial_operand_transmitter_if #(parameter int W = 16);
  logic         in_valid, in_ready, a, b, out_valid, out_first, out_last;
  logic [W-1:0] in_a, in_b;
`ifdef SERIAL_TX_CLEAR_EN
  logic         cmp_clr;
  modport master (output in_valid, in_a, in_b,
                  input  in_ready, a, b, out_valid, out_first, out_last, cmp_clr);
  modport slave  (input  in_valid, in_a, in_b,
                  output in_ready, a, b, out_valid, out_first, out_last, cmp_clr);
`else
  modport master (output in_valid, in_a, in_b,
                  input  in_ready, a, b, out_valid, out_first, out_last);
  modport slave  (input  in_valid, in_a, in_b,
                  output in_ready, a, b, out_valid, out_first, out_last);
`endif
endinterface

// File: rtl/serial_operand_transmitter.sv
// serial_operand_transmitter: shifts a W-bit operand pair out one bit per clock with frame strobes.
// SERIAL_TX_CLEAR_EN inserts a one-cycle cmp_clr slot before every frame.
module serial_operand_transmitter #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                        clk,
  input logic                        rst_n,
  serial_operand_transmitter_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
`ifdef SERIAL_TX_CLEAR_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CLEAR} state_t;
  localparam state_t ENTRY = CLEAR;
  localparam int PAD = 1;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
  localparam state_t ENTRY = SHIFT;
  localparam int PAD = 0;
`endif
  localparam int SW = W + PAD;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sa_q, sa_d, sb_q, sb_d;
  logic          valid_q, first_q, last_q, clr_q;
  logic          valid_d, first_d, last_d, clr_d;
  logic          at_last, acc;

  // Reorders the operand so the frame always leaves from bit 0 of the shift register.
  function automatic logic [W-1:0] order(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = MSB_FIRST ? v[W-1-i] : v[i];
    return r;
  endfunction

  assign at_last      = state_q == SHIFT && cnt_q == LAST;
  assign bus.in_ready = state_q == IDLE || at_last;
  assign acc          = bus.in_valid && bus.in_ready;

  // The leading zero pad in clear mode keeps a/b low during the clear slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q >> 1;
    sb_d    = sb_q >> 1;
    if (acc) begin
      state_d = ENTRY;
      cnt_d   = '0;
      sa_d    = SW'(order(bus.in_a)) << PAD;
      sb_d    = SW'(order(bus.in_b)) << PAD;
    end else if (at_last) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      cnt_d   = cnt_q + 1'b1;
    end else if (state_q != IDLE) begin
      state_d = SHIFT;
    end
    valid_d = state_d == SHIFT;
    first_d = valid_d && cnt_d == '0;
    last_d  = valid_d && cnt_d == LAST;
    clr_d   = state_d != IDLE && state_d != SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.a         = sa_q[0];
  assign bus.b         = sb_q[0];
  assign bus.out_valid = valid_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
`ifdef SERIAL_TX_CLEAR_EN
  assign bus.cmp_clr   = clr_q;
`endif
endmodule
